// File: rtl/ex_md.sv
// ex_md: execute stage for RV32I/RV64I integer ops plus the M extension.
// Base ops finish in one cycle. Multiplies wait out a MUL_LAT-cycle counter.
// Divides/remainders run a one-bit-per-cycle restoring divider.
// Every result sits in an output register until mem takes it.
// Optional build macro: EX_MD_DIV_EARLY_EN. When it is defined, a divide by
// zero or a signed-overflow divide completes in a single cycle.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | accepting work; base ops load the output register directly
// MUL   | product already formed; counting down to the MUL_LAT boundary
// DIV   | restoring divider iterating, one quotient bit per cycle
module ex_md #(
  parameter int XLEN       = 32,
  parameter int MUL_LAT    = 2,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [XLEN-1:0]       pc_i,
  input  logic [6:0]            opcode_i,
  input  logic [2:0]            funct3_i,
  input  logic [6:0]            funct7_i,
  input  logic [XLEN-1:0]       imm_i,
  input  logic [XLEN-1:0]       rs1_data_i,
  input  logic [XLEN-1:0]       rs2_data_i,
  input  logic                  wreg_en_i,
  input  logic [REG_ADDR_W-1:0] wreg_addr_i,
  input  logic                  wmem_en_i,
  input  logic                  rmem_en_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  wmem_en_o,
  output logic                  rmem_en_o,
  output logic [XLEN-1:0]       mem_addr_o,
  output logic [2:0]            funct3_o,
  output logic                  wreg_en_o,
  output logic [REG_ADDR_W-1:0] wreg_addr_o,
  output logic [XLEN-1:0]       wreg_data_o,
  output logic                  busy_o
);

  localparam int SHW     = $clog2(XLEN);
  localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam bit MUL_ONE = (MUL_LAT == 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] FUNCT7_MD  = 7'b0000001;

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  // State and counter
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Output register
  logic                  valid_q;
  logic                  wmem_en_q, rmem_en_q, wreg_en_q;
  logic [XLEN-1:0]       mem_addr_q, wreg_data_q;
  logic [2:0]            funct3_q;
  logic [REG_ADDR_W-1:0] wreg_addr_q;

  // Metadata of the multi-cycle op in flight
  logic                  pend_wmem_q, pend_rmem_q, pend_wreg_en_q;
  logic [XLEN-1:0]       pend_mem_addr_q, pend_res_q;
  logic [2:0]            pend_funct3_q;
  logic [REG_ADDR_W-1:0] pend_wreg_addr_q;

  // Divider state
  logic [XLEN-1:0] quo_q, rem_q, dvs_q;
  logic            neg_q_q, neg_r_q, is_rem_q, special_q;

  // Handshake and decode
  logic accept, is_m, is_mul, is_div, div_early;
  logic go_mul, go_div, accept_base, mul_done, div_done, load_out;

  assign ready_o = !rst && !flush_i && (state_q == ST_IDLE) && (!valid_q || ready_i);
  assign accept  = valid_i && ready_o;
  assign is_m    = (opcode_i == OPC_OP) && (funct7_i == FUNCT7_MD);
  assign is_mul  = is_m && !funct3_i[2];
  assign is_div  = is_m && funct3_i[2];

  // Base ALU
  logic [XLEN-1:0]        alu_b, base_res;
  logic [SHW-1:0]         shamt;
  logic signed [XLEN-1:0] sra_res;

  assign alu_b   = (opcode_i == OPC_OP) ? rs2_data_i : imm_i;
  assign shamt   = alu_b[SHW-1:0];
  assign sra_res = $signed(rs1_data_i) >>> shamt;

  // Base-op result selection; W-forms and non-writing ops fall to zero
  always_comb begin
    base_res = '0;
    case (opcode_i)
      OPC_OP, OPC_OPIMM: begin
        case (funct3_i)
          3'd0: base_res = (opcode_i == OPC_OP && funct7_i[5]) ? rs1_data_i - alu_b
                                                               : rs1_data_i + alu_b;
          3'd1: base_res = rs1_data_i << shamt;
          3'd2: base_res = {{(XLEN-1){1'b0}}, $signed(rs1_data_i) < $signed(alu_b)};
          3'd3: base_res = {{(XLEN-1){1'b0}}, rs1_data_i < alu_b};
          3'd4: base_res = rs1_data_i ^ alu_b;
          3'd5: base_res = funct7_i[5] ? sra_res : (rs1_data_i >> shamt);
          3'd6: base_res = rs1_data_i | alu_b;
          default: base_res = rs1_data_i & alu_b;
        endcase
      end
      OPC_LUI:            base_res = imm_i << 12;
      OPC_AUIPC:          base_res = pc_i + (imm_i << 12);
      OPC_JAL, OPC_JALR:  base_res = pc_i + XLEN'(4);
      OPC_STORE:          base_res = rs2_data_i;
      default:            base_res = '0;
    endcase
  end

  // Multiplier: one (XLEN+1)-bit signed multiply covers all four sign modes
  logic                     mul_a_sgn, mul_b_sgn;
  logic signed [XLEN:0]     mul_a, mul_b;
  logic signed [2*XLEN+1:0] mul_prod;
  logic [XLEN-1:0]          mul_res;
  logic                     unused_prod_bits;

  assign mul_a_sgn        = (funct3_i[1:0] != 2'b11) && rs1_data_i[XLEN-1];
  assign mul_b_sgn        = !funct3_i[1] && rs2_data_i[XLEN-1];
  assign mul_a            = {mul_a_sgn, rs1_data_i};
  assign mul_b            = {mul_b_sgn, rs2_data_i};
  assign mul_prod         = mul_a * mul_b;
  assign mul_res          = (funct3_i[1:0] == 2'b00) ? mul_prod[XLEN-1:0]
                                                     : mul_prod[2*XLEN-1:XLEN];
  assign unused_prod_bits = ^mul_prod[2*XLEN+1:2*XLEN];

  // Divide setup: magnitudes, result signs and the two corner cases
  logic            div_sgn, a_neg, b_neg, dvs_zero, div_ovf, div_special;
  logic [XLEN-1:0] a_mag, b_mag, div_spec_res;

  assign div_sgn      = !funct3_i[0];
  assign a_neg        = div_sgn && rs1_data_i[XLEN-1];
  assign b_neg        = div_sgn && rs2_data_i[XLEN-1];
  assign a_mag        = a_neg ? -rs1_data_i : rs1_data_i;
  assign b_mag        = b_neg ? -rs2_data_i : rs2_data_i;
  assign dvs_zero     = (rs2_data_i == '0);
  assign div_ovf      = div_sgn && (rs1_data_i == XMIN) && (rs2_data_i == '1);
  assign div_special  = dvs_zero || div_ovf;
  assign div_spec_res = funct3_i[1] ? (dvs_zero ? rs1_data_i : '0)
                                    : (dvs_zero ? '1 : rs1_data_i);

`ifdef EX_MD_DIV_EARLY_EN
  assign div_early = is_div && div_special;
`else
  assign div_early = 1'b0;
`endif

  assign go_mul      = accept && is_mul && !MUL_ONE;
  assign go_div      = accept && is_div && !div_early;
  assign accept_base = accept && !go_mul && !go_div;
  assign mul_done    = (state_q == ST_MUL) && (cnt_q == CNT_W'(1));
  assign div_done    = (state_q == ST_DIV) && (cnt_q == CNT_W'(1));
  assign load_out    = !flush_i && (accept_base || mul_done || div_done);

  // Restoring divider step; the last step feeds sign correction directly
  logic [XLEN:0]   rem_sh;
  logic            rem_ge;
  logic [XLEN-1:0] rem_nx, quo_nx, div_final;

  assign rem_sh    = {rem_q, quo_q[XLEN-1]};
  assign rem_ge    = rem_sh >= {1'b0, dvs_q};
  assign rem_nx    = rem_ge ? XLEN'(rem_sh - {1'b0, dvs_q}) : rem_sh[XLEN-1:0];
  assign quo_nx    = {quo_q[XLEN-2:0], rem_ge};
  assign div_final = special_q ? pend_res_q
                   : is_rem_q  ? (neg_r_q ? -rem_nx : rem_nx)
                               : (neg_q_q ? -quo_nx : quo_nx);

  // Next state and counter; flush discards whatever is in flight
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (go_mul) begin
          state_d = ST_MUL;
          cnt_d   = CNT_W'(MUL_LAT - 1);
        end else if (go_div) begin
          state_d = ST_DIV;
          cnt_d   = CNT_W'(XLEN);
        end
      end
      ST_MUL, ST_DIV: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  // Values loaded into the output register
  logic                  in_idle;
  logic [XLEN-1:0]       res_d, mem_addr_d;
  logic                  wmem_d, rmem_d, wreg_en_d;
  logic [2:0]            funct3_d;
  logic [REG_ADDR_W-1:0] wreg_addr_d;

  assign in_idle = (state_q == ST_IDLE);

  // Pick the result source: fresh base op, finished multiply or finished divide
  always_comb begin
    res_d = base_res;
    if (state_q == ST_MUL)      res_d = pend_res_q;
    else if (state_q == ST_DIV) res_d = div_final;
    else if (is_mul)            res_d = mul_res;
    else if (div_early)         res_d = div_spec_res;
  end

  assign mem_addr_d  = in_idle ? rs1_data_i + imm_i : pend_mem_addr_q;
  assign wmem_d      = in_idle ? wmem_en_i   : pend_wmem_q;
  assign rmem_d      = in_idle ? rmem_en_i   : pend_rmem_q;
  assign wreg_en_d   = in_idle ? wreg_en_i   : pend_wreg_en_q;
  assign funct3_d    = in_idle ? funct3_i    : pend_funct3_q;
  assign wreg_addr_d = in_idle ? wreg_addr_i : pend_wreg_addr_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output register: load on completion, drain on ready_i, hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      wmem_en_q   <= 1'b0;
      rmem_en_q   <= 1'b0;
      wreg_en_q   <= 1'b0;
      mem_addr_q  <= '0;
      wreg_data_q <= '0;
      funct3_q    <= '0;
      wreg_addr_q <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_out) begin
      valid_q     <= 1'b1;
      wmem_en_q   <= wmem_d;
      rmem_en_q   <= rmem_d;
      wreg_en_q   <= wreg_en_d;
      mem_addr_q  <= mem_addr_d;
      wreg_data_q <= res_d;
      funct3_q    <= funct3_d;
      wreg_addr_q <= wreg_addr_d;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  // Capture metadata and precomputed results of a multi-cycle op at acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_wmem_q      <= 1'b0;
      pend_rmem_q      <= 1'b0;
      pend_wreg_en_q   <= 1'b0;
      pend_mem_addr_q  <= '0;
      pend_res_q       <= '0;
      pend_funct3_q    <= '0;
      pend_wreg_addr_q <= '0;
    end else if (go_mul || go_div) begin
      pend_wmem_q      <= wmem_en_i;
      pend_rmem_q      <= rmem_en_i;
      pend_wreg_en_q   <= wreg_en_i;
      pend_mem_addr_q  <= rs1_data_i + imm_i;
      pend_res_q       <= is_mul ? mul_res : div_spec_res;
      pend_funct3_q    <= funct3_i;
      pend_wreg_addr_q <= wreg_addr_i;
    end
  end

  // Divider registers: seed on acceptance, then shift one bit per DIV cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      is_rem_q  <= 1'b0;
      special_q <= 1'b0;
    end else if (go_div) begin
      quo_q     <= a_mag;
      rem_q     <= '0;
      dvs_q     <= b_mag;
      neg_q_q   <= a_neg ^ b_neg;
      neg_r_q   <= a_neg;
      is_rem_q  <= funct3_i[1];
      special_q <= div_special;
    end else if (state_q == ST_DIV) begin
      quo_q <= quo_nx;
      rem_q <= rem_nx;
    end
  end

  assign valid_o     = valid_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign wmem_en_o   = wmem_en_q;
  assign rmem_en_o   = rmem_en_q;
  assign wreg_en_o   = wreg_en_q;
  assign mem_addr_o  = mem_addr_q;
  assign wreg_data_o = wreg_data_q;
  assign funct3_o    = funct3_q;
  assign wreg_addr_o = wreg_addr_q;

endmodule

// File: tb/tb_ex_md.sv
// Directed bench for ex_md (XLEN=32, MUL_LAT=2).
module tb_ex_md;
  localparam int XLEN = 32;
`ifdef EX_MD_DIV_EARLY_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 33;
`endif
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;

  logic            clk = 1'b0;
  logic            rst, flush_i, valid_i, ready_o, ready_i;
  logic [XLEN-1:0] pc_i, imm_i, rs1_data_i, rs2_data_i;
  logic [6:0]      opcode_i, funct7_i;
  logic [2:0]      funct3_i, funct3_o;
  logic            wreg_en_i, wmem_en_i, rmem_en_i;
  logic [4:0]      wreg_addr_i, wreg_addr_o;
  logic            valid_o, wmem_en_o, rmem_en_o, wreg_en_o, busy_o;
  logic [XLEN-1:0] mem_addr_o, wreg_data_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_md #(.XLEN(XLEN), .MUL_LAT(2), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .pc_i(pc_i), .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
    .imm_i(imm_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .wreg_en_i(wreg_en_i), .wreg_addr_i(wreg_addr_i), .wmem_en_i(wmem_en_i),
    .rmem_en_i(rmem_en_i), .valid_o(valid_o), .ready_i(ready_i),
    .wmem_en_o(wmem_en_o), .rmem_en_o(rmem_en_o), .mem_addr_o(mem_addr_o),
    .funct3_o(funct3_o), .wreg_en_o(wreg_en_o), .wreg_addr_o(wreg_addr_o),
    .wreg_data_o(wreg_data_o), .busy_o(busy_o)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [4:0] rd);
    valid_i     = 1'b1;
    opcode_i    = opc;
    funct3_i    = f3;
    funct7_i    = f7;
    rs1_data_i  = a;
    rs2_data_i  = b;
    imm_i       = imm;
    pc_i        = pc;
    wreg_en_i   = 1'b1;
    wreg_addr_i = rd;
    wmem_en_i   = (opc == OPC_STORE);
    rmem_en_i   = (opc == OPC_LOAD);
  endtask

  task automatic base_vec(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic [31:0] pc, input logic [31:0] exp);
    drive(opc, f3, f7, a, b, imm, pc, 5'd1);
    cyc();
    valid_i = 1'b0;
    chk({tag, "_vld"}, valid_o, 1'b1);
    chk(tag, wreg_data_o, exp);
  endtask

  task automatic mul_vec(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    drive(OPC_OP, f3, 7'h01, a, b, 32'd0, 32'd0, 5'd6);
    #1;
    chk({tag, "_rdy"}, ready_o, 1'b1);
    cyc();
    valid_i = 1'b0;
    chk({tag, "_wait"}, {valid_o, busy_o, ready_o}, 3'b010);
    cyc();
    chk({tag, "_done"}, {valid_o, busy_o}, 2'b10);
    chk(tag, wreg_data_o, exp);
  endtask

  task automatic div_vec(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
    int odd;
    odd = 0;
    drive(OPC_OP, f3, 7'h01, a, b, 32'd0, 32'd0, 5'd8);
    #1;
    chk({tag, "_rdy"}, ready_o, 1'b1);
    cyc();
    valid_i = 1'b0;
    for (int k = 1; k < lat; k++) begin
      if ({valid_o, busy_o, ready_o} !== 3'b010) odd++;
      cyc();
    end
    chk({tag, "_busy"}, odd, 0);
    chk({tag, "_done"}, {valid_o, busy_o}, 2'b10);
    chk(tag, wreg_data_o, exp);
  endtask

  initial begin
    int seen;
    rst = 1'b1; flush_i = 1'b0; ready_i = 1'b1;
    valid_i = 1'b0; opcode_i = '0; funct3_i = '0; funct7_i = '0;
    rs1_data_i = '0; rs2_data_i = '0; imm_i = '0; pc_i = '0;
    wreg_en_i = 1'b0; wreg_addr_i = '0; wmem_en_i = 1'b0; rmem_en_i = 1'b0;
    repeat (3) cyc();
    chk("rst_state", {valid_o, busy_o, wreg_en_o, wmem_en_o, rmem_en_o}, 5'b0);
    chk("rst_data", wreg_data_o, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    rst = 1'b0;
    cyc();
    chk("rst_ready", ready_o, 1'b1);

    // ADDI 5 + (-7)
    drive(OPC_OPIMM, 3'd0, 7'd0, 32'd5, 32'd0, 32'hFFFF_FFF9, 32'd0, 5'd3);
    cyc();
    valid_i = 1'b0;
    chk("addi_vld", valid_o, 1'b1);
    chk("addi_data", wreg_data_o, 32'hFFFF_FFFE);
    chk("addi_meta", {wreg_en_o, wreg_addr_o, funct3_o}, {1'b1, 5'd3, 3'd0});
    chk("addi_addr", mem_addr_o, 32'hFFFF_FFFE);

    // four back-to-back ADDs
    for (int i = 1; i <= 4; i++) begin
      drive(OPC_OP, 3'd0, 7'd0, i, 10 * i, 32'd0, 32'd0, 5'(i));
      cyc();
      chk("b2b_vld", valid_o, 1'b1);
      chk("b2b_data", wreg_data_o, 32'(11 * i));
    end
    valid_i = 1'b0;
    cyc();
    chk("b2b_drain", valid_o, 1'b0);

    base_vec("srai",  OPC_OPIMM, 3'd5, 7'h20, 32'h8000_0000, 32'd0, 32'h404, 32'd0, 32'hF800_0000);
    base_vec("srl",   OPC_OP,    3'd5, 7'h00, 32'h8000_0000, 32'h24, 32'd0, 32'd0, 32'h0800_0000);
    base_vec("sll",   OPC_OP,    3'd1, 7'h00, 32'd1, 32'd31, 32'd0, 32'd0, 32'h8000_0000);
    base_vec("slt",   OPC_OP,    3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd1);
    base_vec("sltu",  OPC_OP,    3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0);
    base_vec("xori",  OPC_OPIMM, 3'd4, 7'h00, 32'h0000_F0F0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_0F0F);
    base_vec("and",   OPC_OP,    3'd7, 7'h00, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 32'd0, 32'h0F00_0F00);
    base_vec("lui",   OPC_LUI,   3'd0, 7'h00, 32'd0, 32'd0, 32'h0001_2345, 32'd0, 32'h1234_5000);
    base_vec("auipc", OPC_AUIPC, 3'd0, 7'h00, 32'd0, 32'd0, 32'd1, 32'h1000, 32'h2000);
    base_vec("jal",   OPC_JAL,   3'd0, 7'h00, 32'd0, 32'd0, 32'd0, 32'h100, 32'h104);
    base_vec("load",  OPC_LOAD,  3'd2, 7'h00, 32'h40, 32'd9, 32'd4, 32'd0, 32'd0);
    chk("load_flags", {rmem_en_o, wmem_en_o}, 2'b10);
    base_vec("store", OPC_STORE, 3'd2, 7'h00, 32'h100, 32'hDEAD_BEEF, 32'd8, 32'd0, 32'hDEAD_BEEF);
    chk("store_addr", mem_addr_o, 32'h108);
    chk("store_flags", {rmem_en_o, wmem_en_o}, 2'b01);

    mul_vec("mul",    3'd0, 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE);
    mul_vec("mulh",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    mul_vec("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    mul_vec("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);

    div_vec("div",      3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33);
    div_vec("rem",      3'd6, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33);
    div_vec("divu",     3'd5, 32'd100, 32'd7, 32'd14, 33);
    div_vec("remu",     3'd7, 32'd100, 32'd7, 32'd2, 33);
    div_vec("divu_z",   3'd5, 32'd7, 32'd0, 32'hFFFF_FFFF, SPEC_LAT);
    div_vec("remu_z",   3'd7, 32'd7, 32'd0, 32'd7, SPEC_LAT);
    div_vec("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPEC_LAT);
    div_vec("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT);

    // output hold with mem stalled
    cyc();
    ready_i = 1'b0;
    drive(OPC_OP, 3'd0, 7'h20, 32'd10, 32'd3, 32'd0, 32'd0, 5'd7);
    cyc();
    drive(OPC_OPIMM, 3'd0, 7'h00, 32'd1, 32'd0, 32'd1, 32'd0, 5'd9);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_rdy", ready_o, 1'b0);
      chk("hold_vld", valid_o, 1'b1);
      chk("hold_data", wreg_data_o, 32'd7);
      chk("hold_rd", wreg_addr_o, 5'd7);
      cyc();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    #1;
    chk("hold_rel_rdy", ready_o, 1'b1);
    cyc();
    chk("hold_drop", valid_o, 1'b0);

    // flush at DIV cycle 10 with a competing valid_i
    drive(OPC_OP, 3'd4, 7'h01, 32'd1000, 32'd7, 32'd0, 32'd0, 5'd4);
    cyc();
    valid_i = 1'b0;
    repeat (9) cyc();
    chk("flush_pre_busy", busy_o, 1'b1);
    drive(OPC_OPIMM, 3'd0, 7'h00, 32'd5, 32'd0, 32'd1, 32'd0, 5'd2);
    flush_i = 1'b1;
    #1;
    chk("flush_rdy", ready_o, 1'b0);
    cyc();
    flush_i = 1'b0;
    valid_i = 1'b0;
    chk("flush_idle", {valid_o, busy_o}, 2'b00);
    cyc();
    chk("flush_ready", ready_o, 1'b1);
    seen = 0;
    repeat (40) begin
      cyc();
      if (valid_o !== 1'b0) seen++;
    end
    chk("flush_novld", seen, 0);

    // reset in the middle of a DIV
    drive(OPC_OP, 3'd5, 7'h01, 32'd1000, 32'd7, 32'd0, 32'd0, 5'd4);
    cyc();
    valid_i = 1'b0;
    repeat (4) cyc();
    chk("rstdiv_pre_busy", busy_o, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rstdiv_idle", {valid_o, busy_o}, 2'b00);
    chk("rstdiv_data", wreg_data_o, 32'd0);
    cyc();
    chk("rstdiv_ready", ready_o, 1'b1);
    seen = 0;
    repeat (40) begin
      cyc();
      if (valid_o !== 1'b0) seen++;
    end
    chk("rstdiv_novld", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
